// File: rtl/ham_unpack_if.sv
// rtl/ham_unpack_if.sv - codeword-in / byte-out handshake bundle for ham_unpack
interface ham_unpack_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:1] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_last;

  modport slave (
    input  in_valid, in_word, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );

  modport master (
    output in_valid, in_word, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );
endinterface

// File: rtl/ham_unpack.sv
// rtl/ham_unpack.sv - strips Hamming(15,11) parity and packs payloads LSB-first into bytes
module ham_unpack #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  ham_unpack_if.slave      bus,
  input  logic             flush,
  output logic             flush_done,
  output logic             syn_err,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, PAD = 2'd2} state_t;

  state_t      state, state_n;
  logic [17:0] acc, acc_n;
  logic [4:0]  cnt, cnt_n;
  logic        done_n;
  logic [10:0] d;
  logic [17:0] d_ext;
  logic [3:0]  syn;
  logic [7:0]  pad_mask;
  logic        out_valid_i, in_ready_i, in_fire, out_fire;

  assign d = {bus.in_word[15], bus.in_word[14], bus.in_word[13], bus.in_word[12],
              bus.in_word[11], bus.in_word[10], bus.in_word[9],  bus.in_word[7],
              bus.in_word[6],  bus.in_word[5],  bus.in_word[3]};
  assign d_ext = {7'd0, d};

  // Syndrome is the XOR of the indices of all set bits; zero for a clean codeword.
  always_comb begin
    syn = '0;
    for (int i = 1; i <= 15; i++) begin
      if (bus.in_word[i]) syn = syn ^ 4'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) pad_mask[i] = (5'(i) < cnt);
  end

  // in_ready looks through out_ready so a full byte can leave while a word lands.
  assign out_valid_i = (state == PAD) || (cnt >= 5'd8);
  assign in_ready_i  = (state == RUN) &&
                       ((cnt <= 5'd7) || ((cnt <= 5'd15) && out_valid_i && bus.out_ready));
  assign in_fire     = bus.in_valid && in_ready_i;
  assign out_fire    = out_valid_i && bus.out_ready;

  assign bus.out_valid = out_valid_i;
  assign bus.in_ready  = in_ready_i;
  assign bus.out_last  = (state == PAD);
  assign bus.out_byte  = (state == PAD) ? (acc[7:0] & pad_mask) : acc[7:0];

  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    done_n  = 1'b0;

    case (state)
      RUN: begin
        if (flush) state_n = DRAIN;
      end
      DRAIN: begin
        if (cnt < 5'd8) begin
          if (cnt == 5'd0) begin
            done_n  = 1'b1;
            state_n = RUN;
          end else begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        if (out_fire) begin
          done_n  = 1'b1;
          state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase

    if (state == PAD) begin
      if (out_fire) begin
        acc_n = '0;
        cnt_n = '0;
      end
    end else if (in_fire && out_fire) begin
      acc_n = (acc >> 8) | (d_ext << (cnt - 5'd8));
      cnt_n = cnt + 5'd3;
    end else if (out_fire) begin
      acc_n = acc >> 8;
      cnt_n = cnt - 5'd8;
    end else if (in_fire) begin
      acc_n = acc | (d_ext << cnt);
      cnt_n = cnt + 5'd11;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      acc        <= '0;
      cnt        <= '0;
      flush_done <= 1'b0;
      syn_err    <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      cnt        <= cnt_n;
      flush_done <= done_n;
      if (in_fire) begin
        word_count <= word_count + 1'b1;
        if (syn != 4'd0) syn_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ham_unpack.md
Name: ham_unpack

Overview:
- Downstream stage of the Hamming(15,11) corrector.
- Consumes corrected 15-bit codewords, strips the parity positions, and bit-packs the 11-bit payloads LSB-first into an 8-bit byte stream.
- Input and output both use valid/ready handshakes.
- A flush request drains the buffer and emits the trailing partial byte, zero-padded and tagged last.

Parameters:
- CNT_W, 16, width of the accepted-codeword counter (wraps).

Ports:
- clock  in  1  single rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  codeword present on in_word
- in_ready  out  1  block accepts in_word this cycle
- in_word  in  15  corrected codeword, bit index [15:1]
- flush  in  1  one-cycle request to drain and pad
- out_valid  out  1  byte present on out_byte
- out_ready  in  1  consumer accepts out_byte
- out_byte  out  8  packed payload byte
- out_last  out  1  marks the final byte of a flush
- flush_done  out  1  one-cycle pulse when a flush completes
- syn_err  out  1  sticky flag: an accepted word had a nonzero syndrome
- word_count  out  CNT_W  accepted codewords, modulo 2^CNT_W

Behaviour:
- Reset is asynchronous on reset_n low. While in reset:
  - acc = 0, cnt = 0, state = RUN, word_count = 0, syn_err = 0.
  - Outputs out_valid, out_last and flush_done are all 0.
- Payload extraction: d[1..11] = in_word[3,5,6,7,9,10,11,12,13,14,15].
- Bit order: d[1] is the first bit shifted out, i.e. the earliest stream bit.
- Accumulator: acc is 18 bits; cnt (0..18) is the number of valid LSB bits.
- out_byte = acc[7:0].
- Handshakes:
  - Input handshake fires on in_valid & in_ready.
  - Output handshake fires on out_valid & out_ready.
- State RUN:
  - out_valid = (cnt >= 8).
  - in_ready = (cnt <= 7) | (cnt <= 15 & out_valid & out_ready). This is a combinational path from out_ready and must be documented at integration.
  - Output fire only: acc >>= 8, cnt -= 8.
  - Input fire only: acc |= d << cnt, cnt += 11.
  - Both fire in the same cycle: acc = (acc >> 8) | (d << (cnt - 8)), cnt = cnt + 3. Maximum cnt is 18; it never overflows.
  - Every input fire:
    - word_count increments, wrapping.
    - Recompute the syndrome; if nonzero, set syn_err. syn_err clears only on reset.
  - flush sampled high → go to DRAIN. A word accepted in the same cycle is included in the drain.
- State DRAIN:
  - in_ready = 0.
  - Full bytes are emitted normally.
  - When cnt < 8:
    - cnt == 0 → pulse flush_done, go to RUN.
    - cnt in 1..7 → go to PAD.
- State PAD:
  - out_valid = 1, out_last = 1, out_byte = acc[7:0] with bits [7:cnt] forced to 0.
  - On output fire: acc = 0, cnt = 0, pulse flush_done, go to RUN.
  - out_last is never asserted in any other state.
- flush asserted while not in RUN is ignored.
- out_byte and out_valid must hold stable while out_valid & !out_ready.
- Latency: a byte completed by an input fire is valid the next cycle.
- Reset mid-flush abandons the partial byte; no out_last is emitted.

Test Plan:
1. Single byte: in_word 15'h7FFF (d = 11'h7FF), out_ready = 1.
   - Next cycle out_byte 8'hFF.
   - Then cnt = 3, out_valid = 0; word_count = 1, syn_err = 0.
2. Two words, then flush: 15'h7FFF followed by 15'h0007 (d = 11'h001), then flush.
   - Bytes in order: 8'hFF, 8'h0F, then 8'h00 with out_last = 1.
   - flush_done pulses on the cycle after the last byte is accepted.
3. Backpressure: out_ready = 0 with in_valid held high.
   - Exactly one word accepted, which gives cnt = 11; in_ready then stays 0.
   - out_byte stays stable until out_ready rises.
   - Full ordered stream of 8 words = 88 bits = 11 bytes, all matching the reference packer.
4. Flush with empty buffer: after 8 words (cnt = 0), pulse flush.
   - flush_done = 1 one cycle later; no out_last byte emitted.
   - flush while in DRAIN is ignored.
5. Syndrome error: in_word 15'h0001.
   - syn_err rises the cycle after acceptance and stays high until reset_n low.
   - word_count wraps 16'hFFFF → 0 when CNT_W = 16 (force via 65536 words, or use CNT_W = 4 → 16 words).
6. Async reset mid-flush: reset_n low during PAD.
   - out_valid, out_last and cnt go to 0 immediately.
   - After release, 15'h7FFF again yields 8'hFF.
